// File: rtl/nios2_system_led_sequencer_if.sv
// Avalon-MM slave bus for the LED sequencer: 2-bit address, 32-bit data, zero wait states.
interface nios2_system_led_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_system_led_sequencer.sv
// Autonomous LED pattern sequencer (static/rotate/bounce/blink) on an Avalon-MM slave.
// Define LED_SEQ_IRQ_EN to build the wrap flag, CTRL.irq_en and the irq output.
module nios2_system_led_sequencer #(
  parameter int unsigned         PERIOD_W      = 24,
  parameter logic [PERIOD_W-1:0] RESET_PERIOD  = 24'd4999999,
  parameter logic [7:0]          RESET_PATTERN = 8'h01
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nios2_system_led_sequencer_if.slave  bus,
  output logic [7:0]                   out_port,
  output logic                         irq
);

  typedef enum logic {StIdle, StRun} state_e;
  typedef enum logic [1:0] {ModeStatic, ModeRotate, ModeBounce, ModeBlink} mode_e;

  state_e              state_q;
  mode_e               mode_q;
  mode_e               mode_wr;
  logic [7:0]          pattern_q;
  logic [7:0]          frame_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                dir_q;
  logic [2:0]          step_q;

  logic       wr, wr_pat, wr_per, wr_ctrl, wr_stat;
  logic       tick, step_ok, mode_chg;
  logic [7:0] frame_step;
  logic       dir_step;
  logic       wrap_evt;

  always_comb begin
    wr       = bus.chipselect & ~bus.write_n;
    wr_pat   = wr && (bus.address == 2'd0);
    wr_per   = wr && (bus.address == 2'd1);
    wr_ctrl  = wr && (bus.address == 2'd2);
    wr_stat  = wr && (bus.address == 2'd3);
    mode_wr  = mode_e'(bus.writedata[2:1]);
    mode_chg = wr_ctrl && (mode_wr != mode_q);
    tick     = (state_q == StRun) && (cnt_q == period_q);
    // Any config write in the tick cycle discards that step.
    step_ok  = tick && !(wr_pat || wr_per || wr_ctrl);
  end

  always_comb begin
    frame_step = frame_q;
    dir_step   = dir_q;
    wrap_evt   = 1'b0;
    case (mode_q)
      ModeStatic: frame_step = pattern_q;
      ModeRotate: begin
        frame_step = {frame_q[6:0], frame_q[7]};
        wrap_evt   = (step_q == 3'd7);
      end
      ModeBounce: begin
        if (!dir_q) begin
          if (frame_q[7]) begin
            dir_step   = 1'b1;
            frame_step = frame_q >> 1;
          end else begin
            frame_step = frame_q << 1;
          end
        end else if (frame_q[0]) begin
          dir_step   = 1'b0;
          frame_step = frame_q << 1;
          wrap_evt   = 1'b1;
        end else begin
          frame_step = frame_q >> 1;
        end
      end
      ModeBlink: begin
        if (frame_q == pattern_q) begin
          frame_step = 8'h00;
        end else begin
          frame_step = pattern_q;
          wrap_evt   = (frame_q == 8'h00);
        end
      end
      default: frame_step = frame_q;
    endcase
  end

  // Later assignments override earlier ones: register writes win over the step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mode_q    <= ModeStatic;
      pattern_q <= RESET_PATTERN;
      frame_q   <= RESET_PATTERN;
      period_q  <= RESET_PERIOD;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 3'd0;
    end else begin
      if (state_q == StRun) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (step_ok) begin
        frame_q <= frame_step;
        dir_q   <= dir_step;
        if (mode_q == ModeRotate) begin
          step_q <= step_q + 3'd1;
        end
      end
      if (wr_pat) begin
        pattern_q <= bus.writedata[7:0];
        frame_q   <= bus.writedata[7:0];
        cnt_q     <= '0;
        dir_q     <= 1'b0;
      end
      if (wr_per) begin
        period_q <= bus.writedata[PERIOD_W-1:0];
        cnt_q    <= '0;
      end
      if (wr_ctrl) begin
        state_q <= bus.writedata[0] ? StRun : StIdle;
        mode_q  <= mode_wr;
        if (!bus.writedata[0]) begin
          cnt_q <= '0;
        end
        if (mode_chg) begin
          frame_q <= pattern_q;
          dir_q   <= 1'b0;
          cnt_q   <= '0;
          step_q  <= 3'd0;
        end
      end
    end
  end

  assign out_port = frame_q;

`ifdef LED_SEQ_IRQ_EN
  logic wrap_q, wrap_d;
  logic irq_en_q, irq_en_d;
  logic irq_q;

  always_comb begin
    irq_en_d = wr_ctrl ? bus.writedata[4] : irq_en_q;
    wrap_d   = wrap_q;
    if (wr_stat && bus.writedata[9]) begin
      wrap_d = 1'b0;
    end
    // A fresh wrap event beats a simultaneous clear.
    if (step_ok && wrap_evt) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wrap_q   <= wrap_d;
      irq_en_q <= irq_en_d;
      irq_q    <= wrap_d & irq_en_d;
    end
  end

  assign irq = irq_q;
`else
  logic wrap_q, irq_en_q;
  logic unused_wrap;
  assign wrap_q      = 1'b0;
  assign irq_en_q    = 1'b0;
  assign irq         = 1'b0;
  assign unused_wrap = wrap_evt ^ wr_stat;
`endif

  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata[7:0] = pattern_q;
      2'd1: bus.readdata[PERIOD_W-1:0] = period_q;
      2'd2: begin
        bus.readdata[0]   = (state_q == StRun);
        bus.readdata[2:1] = mode_q;
        bus.readdata[4]   = irq_en_q;
      end
      default: begin
        bus.readdata[7:0] = frame_q;
        bus.readdata[8]   = dir_q;
        bus.readdata[9]   = wrap_q;
      end
    endcase
  end

endmodule
